// File: rtl/isqrt_iterative.sv
// Sequential integer square root: digit-by-digit restoring algorithm, one root bit per clock.
// Returns floor(sqrt(x)) and remainder x - root^2 behind valid/ready handshakes.
module isqrt_iterative #(
  parameter int IN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_WIDTH/2-1:0] out_root,
  output logic [IN_WIDTH/2:0]   out_rem,
  output logic                  busy
);
  localparam int RW = IN_WIDTH / 2;
  localparam int CW = $clog2(RW);

  generate
    if ((IN_WIDTH % 2) != 0 || IN_WIDTH < 4) begin : g_bad_width
      $error("isqrt_iterative: IN_WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IN_WIDTH-1:0] x_reg;
  logic [RW+1:0]       rem_reg;
  logic [RW-1:0]       root_reg;
  logic [CW-1:0]       cnt_reg;

  logic [RW+3:0]       rem_shift, trial;
  logic [RW+1:0]       rem_step;
  logic [RW-1:0]       root_step;
  logic                fits;

  // One restoring step: bring down the next two radicand bits and try 4*root+1.
  always_comb begin
    rem_shift = {rem_reg, x_reg[IN_WIDTH-1 -: 2]};
    trial     = {2'b00, root_reg, 2'b01};
    fits      = (rem_shift >= trial);
    rem_step  = (RW+2)'(fits ? rem_shift - trial : rem_shift);
    root_step = {root_reg[RW-2:0], fits};
  end

  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt_reg  <= '0;
      out_root <= '0;
      out_rem  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= in_data;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= CW'(RW - 1);
          end
        end
        CALC: begin
          x_reg    <= {x_reg[IN_WIDTH-3:0], 2'b00};
          rem_reg  <= rem_step;
          root_reg <= root_step;
          // Final remainder is bounded by 2*root, so RW+1 bits always suffice.
          if (cnt_reg == '0) begin
            out_root <= root_step;
            out_rem  <= (RW+1)'(rem_step);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
